// File: rtl/video_rotate_pkg.sv
// Shared types and helpers for the rotating video crossbar.
package video_rotate_pkg;

  // Switch controller states
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    BLANK
  } state_t;

  // Width of a rotation index for n channels (at least 1 bit)
  function automatic int unsigned rot_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // t+1 modulo n
  function automatic int unsigned mod_inc(input int unsigned t, input int unsigned n);
    return (t == n - 32'd1) ? 32'd0 : t + 32'd1;
  endfunction

  // t-1 modulo n
  function automatic int unsigned mod_dec(input int unsigned t, input int unsigned n);
    return (t == 32'd0) ? n - 32'd1 : t - 32'd1;
  endfunction

endpackage

// File: rtl/video_rotate_switch_xbar.sv
// Combinational N-input barrel mux: out[j] = in[(j - rot) mod N_CH].
// Ports: rot (rotation), in_bus (N_CH lanes of DW), out_bus_c (rotated lanes).
module rotate_xbar
  import video_rotate_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 32,
  localparam int unsigned RW  = rot_w(N_CH)
) (
  input  logic [RW-1:0]        rot,
  input  logic [N_CH*DW-1:0]   in_bus,
  output logic [N_CH*DW-1:0]   out_bus_c
);

  int unsigned src;

  // Lane select; adding N_CH keeps the subtraction non-negative
  always_comb begin
    out_bus_c = '0;
    src       = 0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      src = (j + N_CH - 32'(rot)) % N_CH;
      out_bus_c[j*DW +: DW] = in_bus[src*DW +: DW];
    end
  end

endmodule

// File: rtl/video_rotate_switch.sv
// N-channel video crossbar with frame-aligned rotation changes and an
// optional output blanking gap after each switch.
// Ports: video_clk/video_rst (sync, active-high); in_en/in_data per-channel
// video; frame_start boundary strobe; rot_inc/rot_dec/rot_load/rot_val
// rotation requests; out_en/out_data rotated registered video; rot_cur
// applied rotation; switch_busy high while a switch is pending or blanking.
module video_rotate_switch
  import video_rotate_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DW           = 32,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned RW          = rot_w(N_CH)
) (
  input  logic                 video_clk,
  input  logic                 video_rst,
  input  logic [N_CH-1:0]      in_en,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic                 frame_start,
  input  logic                 rot_inc,
  input  logic                 rot_dec,
  input  logic                 rot_load,
  input  logic [RW-1:0]        rot_val,
  output logic [N_CH-1:0]      out_en,
  output logic [N_CH*DW-1:0]   out_data,
  output logic [RW-1:0]        rot_cur,
  output logic                 switch_busy
);

  localparam int unsigned CW = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;

  state_t          state, state_nxt;
  logic [RW-1:0]   target, target_nxt;
  logic [RW-1:0]   rot_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            req_seen, req_seen_nxt;
  logic            req_vld_c;
  logic            blank_c;
  int unsigned     base_c;
  int unsigned     res_c;
  logic [N_CH*DW-1:0] xbar_data_c;
  logic [N_CH-1:0]    xbar_en_c;

  // Resolve this cycle's request against the current base rotation
  always_comb begin
    req_vld_c = 1'b0;
    base_c    = (state == IDLE) ? 32'(rot_cur) : 32'(target);
    res_c     = base_c;
    if (rot_load) begin
      if (32'(rot_val) < N_CH) begin
        req_vld_c = 1'b1;
        res_c     = 32'(rot_val);
      end
    end else if (rot_inc && !rot_dec) begin
      req_vld_c = 1'b1;
      res_c     = mod_inc(base_c, N_CH);
    end else if (rot_dec && !rot_inc) begin
      req_vld_c = 1'b1;
      res_c     = mod_dec(base_c, N_CH);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    rot_nxt      = rot_cur;
    cnt_nxt      = cnt;
    req_seen_nxt = req_seen;
    case (state)
      IDLE: begin
        if (req_vld_c && (RW'(res_c) != rot_cur)) begin
          target_nxt = RW'(res_c);
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (req_vld_c) target_nxt = RW'(res_c);
        if (frame_start) begin
          if (target_nxt == rot_cur) begin
            state_nxt = IDLE;
          end else begin
            rot_nxt = target_nxt;
            if (BLANK_CYCLES > 0) begin
              state_nxt    = BLANK;
              cnt_nxt      = CW'(BLANK_CYCLES - 1);
              req_seen_nxt = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      BLANK: begin
        if (req_vld_c) begin
          target_nxt   = RW'(res_c);
          req_seen_nxt = 1'b1;
        end
        if (cnt == '0) state_nxt = (req_vld_c || req_seen) ? PENDING : IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output of this edge is blanked exactly when the controller will sit in BLANK
  assign blank_c = (state_nxt == BLANK);

  // Rotate with the next rotation so a committed switch shows on the very next output
  rotate_xbar #(.N_CH(N_CH), .DW(DW)) u_xbar_data (
    .rot       (rot_nxt),
    .in_bus    (in_data),
    .out_bus_c (xbar_data_c)
  );

  rotate_xbar #(.N_CH(N_CH), .DW(1)) u_xbar_en (
    .rot       (rot_nxt),
    .in_bus    (in_en),
    .out_bus_c (xbar_en_c)
  );

  // State and output registers
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      state       <= IDLE;
      rot_cur     <= '0;
      target      <= '0;
      cnt         <= '0;
      req_seen    <= 1'b0;
      out_en      <= '0;
      out_data    <= '0;
      switch_busy <= 1'b0;
    end else begin
      state       <= state_nxt;
      rot_cur     <= rot_nxt;
      target      <= target_nxt;
      cnt         <= cnt_nxt;
      req_seen    <= req_seen_nxt;
      out_en      <= blank_c ? '0 : xbar_en_c;
      out_data    <= blank_c ? '0 : xbar_data_c;
      switch_busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_video_rotate_switch.sv
// Self-checking bench: 4-channel/16-blank instance against a scoreboard model,
// plus a 3-channel/no-blank instance for odd modulo wrap and direct switching.
module tb_video_rotate_switch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [3:0]   in_en4 = '0;
  logic [127:0] in_data4 = '0;
  logic         fs4 = 1'b0, inc4 = 1'b0, dec4 = 1'b0, load4 = 1'b0;
  logic [1:0]   val4 = '0;
  logic [3:0]   out_en4;
  logic [127:0] out_data4;
  logic [1:0]   rot4;
  logic         busy4;

  // 3-channel instance
  logic [2:0]   in_en3 = '0;
  logic [95:0]  in_data3 = '0;
  logic         fs3 = 1'b0, inc3 = 1'b0, dec3 = 1'b0, load3 = 1'b0;
  logic [1:0]   val3 = '0;
  logic [2:0]   out_en3;
  logic [95:0]  out_data3;
  logic [1:0]   rot3;
  logic         busy3;

  video_rotate_switch #(.N_CH(4), .DW(32), .BLANK_CYCLES(16)) u_dut4 (
    .video_clk(clk), .video_rst(rst), .in_en(in_en4), .in_data(in_data4),
    .frame_start(fs4), .rot_inc(inc4), .rot_dec(dec4), .rot_load(load4),
    .rot_val(val4), .out_en(out_en4), .out_data(out_data4), .rot_cur(rot4),
    .switch_busy(busy4)
  );

  video_rotate_switch #(.N_CH(3), .DW(32), .BLANK_CYCLES(0)) u_dut3 (
    .video_clk(clk), .video_rst(rst), .in_en(in_en3), .in_data(in_data3),
    .frame_start(fs3), .rot_inc(inc3), .rot_dec(dec3), .rot_load(load3),
    .rot_val(val3), .out_en(out_en3), .out_data(out_data3), .rot_cur(rot3),
    .switch_busy(busy3)
  );

  typedef struct packed {
    logic [3:0]   en;
    logic [127:0] data;
    logic [1:0]   rot;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [127:0] last_in4;
  logic [95:0]  last_in3;

  // Reference model of the 4-channel switch (state 0 idle, 1 pending, 2 blank)
  int m_state = 0, m_rot = 0, m_tgt = 0, m_left = 0;
  bit m_req = 0;

  // One cycle on the 4-channel instance: drive, predict, push, then pop and compare
  task automatic step4(input logic inc, input logic dec, input logic load,
                       input logic [1:0] val, input logic fs, input logic rst_i);
    exp_t e, x;
    logic [127:0] d;
    bit has, blank;
    int nv, b, src;
    cyc++;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = (32'(k) << 24) | 32'(cyc);
    in_data4 = d; in_en4 = 4'hf; last_in4 = d;
    inc4 = inc; dec4 = dec; load4 = load; val4 = val; fs4 = fs; rst = rst_i;
    e = '0;
    if (rst_i) begin
      m_state = 0; m_rot = 0; m_tgt = 0; m_left = 0; m_req = 0;
    end else begin
      has = 0; nv = 0;
      b = (m_state == 0) ? m_rot : m_tgt;
      if (load) begin has = 1; nv = int'(val); end
      else if (inc && !dec) begin has = 1; nv = (b + 1) % 4; end
      else if (dec && !inc) begin has = 1; nv = (b + 3) % 4; end
      case (m_state)
        0: if (has && nv != m_rot) begin m_tgt = nv; m_state = 1; end
        1: begin
          if (has) m_tgt = nv;
          if (fs) begin
            if (m_tgt == m_rot) m_state = 0;
            else begin m_rot = m_tgt; m_left = 16; m_req = 0; m_state = 2; end
          end
        end
        default: begin
          if (has) begin m_tgt = nv; m_req = 1; end
          if (m_left == 0) m_state = m_req ? 1 : 0;
        end
      endcase
      blank = (m_left > 0);
      if (blank) m_left--;
      for (int j = 0; j < 4; j++) begin
        src = (j - m_rot + 4) % 4;
        e.data[j*32 +: 32] = blank ? 32'd0 : d[src*32 +: 32];
      end
      e.en   = blank ? 4'h0 : 4'hf;
      e.rot  = 2'(m_rot);
      e.busy = (m_state != 0);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    x = sb.pop_front();
    n_checks++;
    if (out_en4 !== x.en) begin n_err++; $display("FAIL sb_en cyc=%0d got=%h exp=%h", cyc, out_en4, x.en); end
    n_checks++;
    if (out_data4 !== x.data) begin n_err++; $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, out_data4, x.data); end
    n_checks++;
    if (rot4 !== x.rot) begin n_err++; $display("FAIL sb_rot cyc=%0d got=%0d exp=%0d", cyc, rot4, x.rot); end
    n_checks++;
    if (busy4 !== x.busy) begin n_err++; $display("FAIL sb_busy cyc=%0d got=%0d exp=%0d", cyc, busy4, x.busy); end
    inc4 = 0; dec4 = 0; load4 = 0; fs4 = 0; rst = 0;
  endtask

  task automatic idle4(input int n);
    for (int i = 0; i < n; i++) step4(0, 0, 0, 2'd0, 0, 0);
  endtask

  // One cycle on the 3-channel instance
  task automatic step3(input logic inc, input logic dec, input logic load,
                       input logic [1:0] val, input logic fs);
    logic [95:0] d;
    cyc++;
    for (int k = 0; k < 3; k++) d[k*32 +: 32] = (32'(k) << 24) | 32'(cyc);
    in_data3 = d; in_en3 = 3'h7; last_in3 = d;
    inc3 = inc; dec3 = dec; load3 = load; val3 = val; fs3 = fs;
    @(posedge clk); #1;
    inc3 = 0; dec3 = 0; load3 = 0; fs3 = 0;
  endtask

  task automatic test_reset;
    step4(0, 0, 0, 2'd0, 0, 1);
    step4(1, 0, 0, 2'd0, 1, 1);
    n_checks++;
    if (out_en4 !== 4'h0 || out_data4 !== 128'd0) begin n_err++; $display("FAIL reset_out en=%h data=%h exp zero", out_en4, out_data4); end
    n_checks++;
    if (rot4 !== 2'd0 || busy4 !== 1'b0) begin n_err++; $display("FAIL reset_ctl rot=%0d busy=%0d exp 0/0", rot4, busy4); end
    step4(0, 0, 0, 2'd0, 0, 0);
    n_checks++;
    if (out_data4 !== last_in4 || out_en4 !== 4'hf) begin n_err++; $display("FAIL reset_passthru got=%h exp=%h", out_data4, last_in4); end
  endtask

  task automatic test_switch;
    int busy_cnt, blank_cnt;
    busy_cnt = 0; blank_cnt = 0;
    step4(1, 0, 0, 2'd0, 0, 0);
    if (busy4) busy_cnt++;
    for (int i = 0; i < 9; i++) begin
      idle4(1);
      if (busy4) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 10) begin n_err++; $display("FAIL pending_busy got=%0d exp=10", busy_cnt); end
    step4(0, 0, 0, 2'd0, 1, 0);
    if (out_en4 == 4'h0) blank_cnt++;
    n_checks++;
    if (rot4 !== 2'd1) begin n_err++; $display("FAIL commit_rot got=%0d exp=1", rot4); end
    for (int i = 0; i < 15; i++) begin
      idle4(1);
      if (out_en4 == 4'h0) blank_cnt++;
    end
    idle4(1);
    n_checks++;
    if (blank_cnt != 16) begin n_err++; $display("FAIL blank_len got=%0d exp=16", blank_cnt); end
    n_checks++;
    if (out_data4[31:0] !== last_in4[127:96] || out_data4[63:32] !== last_in4[31:0]) begin
      n_err++; $display("FAIL rot1_map got=%h exp=%h_%h", out_data4[63:0], last_in4[31:0], last_in4[127:96]);
    end
  endtask

  task automatic test_dec_wrap;
    step4(0, 0, 1, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    idle4(16);
    step4(0, 1, 0, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    n_checks++;
    if (rot4 !== 2'd3) begin n_err++; $display("FAIL dec_wrap got=%0d exp=3", rot4); end
    idle4(16);
  endtask

  task automatic test_multi_inc;
    int blank_cnt;
    blank_cnt = 0;
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    if (out_en4 == 4'h0) blank_cnt++;
    n_checks++;
    if (rot4 !== 2'd2) begin n_err++; $display("FAIL multi_inc got=%0d exp=2", rot4); end
    for (int i = 0; i < 20; i++) begin
      idle4(1);
      if (out_en4 == 4'h0) blank_cnt++;
    end
    n_checks++;
    if (blank_cnt != 16) begin n_err++; $display("FAIL single_window got=%0d exp=16", blank_cnt); end
    step4(1, 1, 0, 2'd0, 0, 0);
    n_checks++;
    if (busy4 !== 1'b0 || rot4 !== 2'd2) begin n_err++; $display("FAIL inc_dec_noop busy=%0d rot=%0d exp 0/2", busy4, rot4); end
  endtask

  task automatic test_cancel;
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(0, 1, 0, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    n_checks++;
    if (busy4 !== 1'b0 || out_en4 !== 4'hf || rot4 !== 2'd2) begin
      n_err++; $display("FAIL cancel busy=%0d en=%h rot=%0d exp 0/f/2", busy4, out_en4, rot4);
    end
  endtask

  task automatic test_back_to_back;
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    idle4(5);
    step4(1, 0, 0, 2'd0, 0, 0);
    idle4(11);
    n_checks++;
    if (busy4 !== 1'b1 || out_en4 !== 4'hf) begin n_err++; $display("FAIL blank_to_pending busy=%0d en=%h exp 1/f", busy4, out_en4); end
    step4(0, 0, 0, 2'd0, 1, 0);
    n_checks++;
    if (rot4 !== 2'd0) begin n_err++; $display("FAIL b2b_rot got=%0d exp=0", rot4); end
    idle4(16);
  endtask

  task automatic test_rst_blank;
    step4(1, 0, 0, 2'd0, 0, 0);
    step4(0, 0, 0, 2'd0, 1, 0);
    idle4(3);
    step4(0, 0, 0, 2'd0, 0, 1);
    n_checks++;
    if (rot4 !== 2'd0 || out_en4 !== 4'h0 || busy4 !== 1'b0) begin
      n_err++; $display("FAIL rst_in_blank rot=%0d en=%h busy=%0d exp 0/0/0", rot4, out_en4, busy4);
    end
    idle4(1);
    n_checks++;
    if (out_en4 !== 4'hf || out_data4 !== last_in4) begin n_err++; $display("FAIL rst_resume got=%h exp=%h", out_data4, last_in4); end
  endtask

  task automatic test_n3;
    step3(1, 0, 0, 2'd0, 0);
    n_checks++;
    if (busy3 !== 1'b1 || rot3 !== 2'd0) begin n_err++; $display("FAIL n3_pending busy=%0d rot=%0d exp 1/0", busy3, rot3); end
    step3(0, 0, 0, 2'd0, 1);
    n_checks++;
    if (rot3 !== 2'd1 || busy3 !== 1'b0 || out_en3 !== 3'h7) begin
      n_err++; $display("FAIL n3_direct rot=%0d busy=%0d en=%h exp 1/0/7", rot3, busy3, out_en3);
    end
    n_checks++;
    if (out_data3[31:0] !== last_in3[95:64]) begin n_err++; $display("FAIL n3_map1 got=%h exp=%h", out_data3[31:0], last_in3[95:64]); end
    step3(1, 0, 0, 2'd0, 0);
    step3(0, 0, 0, 2'd0, 1);
    step3(1, 0, 0, 2'd0, 0);
    step3(0, 0, 0, 2'd0, 1);
    n_checks++;
    if (rot3 !== 2'd0 || out_data3 !== last_in3) begin n_err++; $display("FAIL n3_wrap_inc rot=%0d data=%h exp 0/%h", rot3, out_data3, last_in3); end
    step3(0, 1, 0, 2'd0, 0);
    step3(0, 0, 0, 2'd0, 1);
    n_checks++;
    if (rot3 !== 2'd2) begin n_err++; $display("FAIL n3_wrap_dec got=%0d exp=2", rot3); end
    step3(1, 0, 1, 2'd3, 0);
    n_checks++;
    if (busy3 !== 1'b0 || rot3 !== 2'd2) begin n_err++; $display("FAIL n3_bad_load busy=%0d rot=%0d exp 0/2", busy3, rot3); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_switch;
    test_dec_wrap;
    test_multi_inc;
    test_cancel;
    test_back_to_back;
    test_rst_blank;
    test_n3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
